// File: rtl/ysyx_lsu_pkg.sv
// Shared encodings, FSM state type and alignment rule for the load/store unit.
`timescale 1ns/1ps
package ysyx_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Size 2'b11 is illegal and behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational byte-lane logic: store lane replication/masking and load
// lane extraction with sign or zero extension.
`timescale 1ns/1ps
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_lane_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    st_wmask     = 4'b1111;
    st_lane_data = st_wdata;
    case (st_size)
      SZ_B: begin
        st_wmask     = 4'b0001 << st_off;
        st_lane_data = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_wmask     = 4'b0011 << {st_off[1], 1'b0};
        st_lane_data = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_data = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one request at a time, forwarded to a word-wide
// valid/ready memory port, completing with a one-cycle resp_valid pulse.
`timescale 1ns/1ps
module ysyx_lsu
  import ysyx_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  lsu_state_e  state;
  logic        lat_wen;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_unsigned;

  logic [3:0]        st_wmask;
  logic [DATA_W-1:0] st_lane_data;
  logic [DATA_W-1:0] ld_data;

  // Store lanes come from the live request (used only at accept); load
  // extraction uses the latched fields since the data arrives later.
  ysyx_lsu_align u_align (
    .st_size      (req_size),
    .st_off       (req_addr[1:0]),
    .st_wdata     (req_wdata),
    .st_wmask     (st_wmask),
    .st_lane_data (st_lane_data),
    .ld_size      (lat_size),
    .ld_off       (lat_off),
    .ld_unsigned  (lat_unsigned),
    .ld_rdata     (mem_resp_rdata),
    .ld_data      (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= 4'b0000;
      lat_wen       <= 1'b0;
      lat_size      <= 2'b00;
      lat_off       <= 2'b00;
      lat_unsigned  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_wen      <= req_wen;
            lat_size     <= req_size;
            lat_off      <= req_addr[1:0];
            lat_unsigned <= req_unsigned;
            req_ready    <= 1'b0;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              // Fault completes locally; memory never sees the access.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_wen   <= req_wen;
              mem_req_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_req_wmask <= req_wen ? st_wmask : 4'b0000;
              mem_req_wdata <= req_wen ? st_lane_data : '0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= 4'b0000;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= lat_wen ? '0 : ld_data;
            state      <= DONE;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: zero-wait vector table plus stall, misalign
// and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_ysyx_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wen        (req_wen),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] mem_rdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
  endtask

  task automatic drive_req(input vec_t v);
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
  endtask

  // Zero-wait transaction: accept at edge 0, handshake at edge 1, memory
  // response at edge 2, resp_valid visible in cycle 3 (cycle 1 on a fault).
  task automatic run_vec(input vec_t v);
    mem_req_ready = 1'b1;
    @(negedge clk);
    check({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.exp_err) begin
      check({v.name, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
      check({v.name, " resp_valid c1"}, 32'(resp_valid), 32'd1);
      check({v.name, " resp_err"}, 32'(resp_err), 32'd1);
      check({v.name, " resp_rdata"}, resp_rdata, 32'd0);
      check({v.name, " req_ready c1"}, 32'(req_ready), 32'd0);
    end else begin
      check({v.name, " mem_req_valid"}, 32'(mem_req_valid), 32'd1);
      check({v.name, " mem_req_wen"}, 32'(mem_req_wen), 32'(v.wen));
      check({v.name, " mem_req_addr"}, mem_req_addr, v.exp_addr);
      check({v.name, " mem_req_wmask"}, 32'(mem_req_wmask), 32'(v.exp_wmask));
      if (v.wen) check({v.name, " mem_req_wdata"}, mem_req_wdata, v.exp_wdata);
      @(negedge clk);
      check({v.name, " mem_req_valid c2"}, 32'(mem_req_valid), 32'd0);
      check({v.name, " resp_valid c2"}, 32'(resp_valid), 32'd0);
      mem_resp_valid = 1'b1;
      mem_resp_rdata = v.mem_rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      check({v.name, " resp_valid c3"}, 32'(resp_valid), 32'd1);
      check({v.name, " resp_err"}, 32'(resp_err), 32'd0);
      check({v.name, " resp_rdata"}, resp_rdata, v.exp_rdata);
    end
    @(negedge clk);
    check({v.name, " resp_valid after"}, 32'(resp_valid), 32'd0);
    check({v.name, " req_ready after"}, 32'(req_ready), 32'd1);
  endtask

  function automatic vec_t mk(input string name, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                              input logic [31:0] mem_rdata, input logic exp_err,
                              input logic [31:0] exp_addr, input logic [3:0] exp_wmask,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    vec_t v;
    v.name = name; v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.mem_rdata = mem_rdata; v.exp_err = exp_err; v.exp_addr = exp_addr;
    v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  initial begin
    vec_t v;
    idle_inputs();
    mem_req_ready = 1'b1;
    rst_n = 1'b0;

    //        name        wen addr          wdata         size  uns mem_rdata     err exp_addr      mask     exp_wdata     exp_rdata
    vecs.push_back(mk("sw",    1, 32'h80000004, 32'hDEADBEEF, 2'b10, 0, 32'h55555555, 0, 32'h80000004, 4'b1111, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("sb3",   1, 32'h80000003, 32'h000000A5, 2'b00, 0, 32'h0,        0, 32'h80000000, 4'b1000, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk("sb0",   1, 32'h80000010, 32'h1234567E, 2'b00, 0, 32'h0,        0, 32'h80000010, 4'b0001, 32'h7E7E7E7E, 32'h0));
    vecs.push_back(mk("sh2",   1, 32'h80000002, 32'h1234ABCD, 2'b01, 0, 32'h0,        0, 32'h80000000, 4'b1100, 32'hABCDABCD, 32'h0));
    vecs.push_back(mk("lb",    0, 32'h80000002, 32'h0,        2'b00, 0, 32'h12803456, 0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk("lbu",   0, 32'h80000002, 32'h0,        2'b00, 1, 32'h12803456, 0, 32'h80000000, 4'b0000, 32'h0,        32'h00000080));
    vecs.push_back(mk("lb1",   0, 32'h80000001, 32'h0,        2'b00, 0, 32'h12345678, 0, 32'h80000000, 4'b0000, 32'h0,        32'h00000056));
    vecs.push_back(mk("lh",    0, 32'h80000002, 32'h0,        2'b01, 0, 32'h80011234, 0, 32'h80000000, 4'b0000, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk("lhu",   0, 32'h80000002, 32'h0,        2'b01, 1, 32'h80011234, 0, 32'h80000000, 4'b0000, 32'h0,        32'h00008001));
    vecs.push_back(mk("lh0",   0, 32'h80000000, 32'h0,        2'b01, 0, 32'h80011234, 0, 32'h80000000, 4'b0000, 32'h0,        32'h00001234));
    vecs.push_back(mk("l11",   0, 32'h80000008, 32'h0,        2'b11, 0, 32'h89ABCDEF, 0, 32'h80000008, 4'b0000, 32'h0,        32'h89ABCDEF));
    vecs.push_back(mk("lw_mis",0, 32'h80000002, 32'h0,        2'b10, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("lh_mis",0, 32'h80000001, 32'h0,        2'b01, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk("sw_mis",1, 32'h80000007, 32'hCAFEF00D, 2'b10, 0, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0));

    #12;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset mem_req_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // lh with memory back-pressure; req_valid stays high while busy.
    v = mk("lh_stall", 0, 32'h80000002, 32'h0, 2'b01, 0, 32'h80011234, 0, 32'h80000000, 4'b0000, 32'h0, 32'hFFFF8001);
    mem_req_ready = 1'b0;
    @(negedge clk);
    drive_req(v);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall mem_req_valid", 32'(mem_req_valid), 32'd1);
      check("stall mem_req_addr", mem_req_addr, 32'h80000000);
      check("stall mem_req_wen", 32'(mem_req_wen), 32'd0);
      check("stall mem_req_wmask", 32'(mem_req_wmask), 32'd0);
      check("stall req_ready", 32'(req_ready), 32'd0);
    end
    mem_req_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall wait mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("stall wait resp_valid", 32'(resp_valid), 32'd0);
      check("stall wait req_ready", 32'(req_ready), 32'd0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h80011234;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    req_valid = 1'b0;
    check("stall resp_valid", 32'(resp_valid), 32'd1);
    check("stall resp_rdata", resp_rdata, 32'hFFFF8001);
    @(negedge clk);
    check("stall no reaccept req_ready", 32'(req_ready), 32'd1);
    check("stall no reaccept resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("stall no reaccept mem_req_valid", 32'(mem_req_valid), 32'd0);

    // Reset while waiting for a load response; late response must be ignored.
    v = mk("lw_rst", 0, 32'h80000010, 32'h0, 2'b10, 0, 32'h0, 0, 32'h80000010, 4'b0000, 32'h0, 32'h0);
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst pre mem_req_valid", 32'(mem_req_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post rst resp_valid", 32'(resp_valid), 32'd0);
      check("post rst req_ready", 32'(req_ready), 32'd1);
      check("post rst mem_req_valid", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
    end
    run_vec(mk("sw_after", 1, 32'h80000020, 32'h0BADF00D, 2'b10, 0, 32'h0, 0, 32'h80000020, 4'b1111, 32'h0BADF00D, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_lsu.md
Name: ysyx_lsu

Overview:
Load/store unit directly downstream of the execute stage. It takes one memory request per transaction: the ALU-computed address, the store data (rs2) and the access size/sign. It drives a word-wide valid/ready memory port with byte write mask. It returns aligned and sign/zero-extended load data, which feeds the register-file write-back mux. It replaces direct per-cycle DPI memory calls with a multi-cycle handshake, so memory latency can vary.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; the byte-lane logic is fixed for 32

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request from execute stage
req_ready  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address (alu_out)
req_wdata  in  DATA_W  store data (rs2)
req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word
req_unsigned  in  1  zero-extend load (lbu/lhu)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_err  out  1  misaligned access, qualified by resp_valid
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  write request
mem_req_addr  out  ADDR_W  word-aligned address {req_addr[31:2],2'b00}
mem_req_wdata  out  DATA_W  lane-replicated store data
mem_req_wmask  out  4  byte write mask; 0000 for loads
mem_resp_valid  in  1  read data or write acknowledge
mem_resp_rdata  in  DATA_W  full word read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; req_ready=1; every other output 0, including latched request registers.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready.
  - On accept, all request fields are latched.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with err=1 and rdata=0. No memory request is issued.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1. mem_req_* outputs stay stable until mem_req_ready. On handshake go to WAIT. mem_resp_valid is ignored in REQ.
- WAIT: on mem_resp_valid, register the extended load data (stores: rdata=0) and go to DONE. Memory may stall indefinitely.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. The consumer cannot back-pressure. req_ready=0 in REQ, WAIT and DONE.
- Minimum latency for an aligned access with a zero-wait memory: accept at cycle 0, mem handshake at cycle 1, mem_resp at cycle 2, resp_valid at cycle 3.
- Misaligned access: resp_valid at cycle 1.
- Store lane generation, with o=addr[1:0]:
  - byte: wmask=0001<<o, wdata={4{wdata[7:0]}}
  - half: wmask=0011<<(2*o[1]), wdata={2{wdata[15:0]}}
  - word: wmask=1111, wdata unchanged
- Load extraction:
  - byte = rdata[8*o +: 8]
  - half = rdata[16*o[1] +: 16]
  - Extension is sign or zero according to the latched req_unsigned.
- Reset mid-operation: immediate return to IDLE. A mem_resp_valid arriving afterwards in IDLE is ignored, and no resp_valid is produced for the aborted access.
- req_valid asserted while busy: held off (req_ready=0), never dropped or double-accepted.

Decomposition:
- Package ysyx_lsu_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - state enum IDLE/REQ/WAIT/DONE
  - misalignment check function
- Sub-module ysyx_lsu_align is purely combinational. It contains:
  - store path: size, offset, wdata -> wmask, lane data
  - load path: size, offset, unsigned, rdata -> extended data
- The FSM stays in ysyx_lsu.

Test Plan:
1. sw addr=0x80000004, wdata=0xDEADBEEF, mem_req_ready=1, resp after 1 cycle -> mem_req_addr=0x80000004, wmask=1111, wdata=0xDEADBEEF; resp_valid at cycle 3, err=0, rdata=0.
2. sb addr=0x80000003, wdata=0x000000A5 -> wmask=1000, mem_req_wdata=0xA5A5A5A5, mem_req_addr=0x80000000.
3. lb addr=0x80000002, mem_resp_rdata=0x12803456 -> resp_rdata=0xFFFFFF80. Repeat with lbu -> 0x00000080.
4. lh addr=0x80000002, mem_resp_rdata=0x80011234 -> 0xFFFF8001. Repeat with lhu -> 0x00008001. Hold mem_req_ready=0 for 4 cycles first -> mem_req_* stable throughout, req_ready=0.
5. lw addr=0x80000002 -> mem_req_valid never asserted; resp_valid at cycle 1, err=1, rdata=0; req_ready=1 next cycle.
6. Accept lw, then deassert rst_n in WAIT and pulse mem_resp_valid after release -> all outputs 0 during reset, req_ready=1, no resp_valid; a following sw completes normally.
